result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer_pkg.sv | 19 +
 rtl/result_serializer_if.sv | 34 +++
 rtl/result_serializer.sv | 115 +++++++++++
 tb/tb_result_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/result_serializer_pkg.sv
// Shared definitions for the result serializer: result width, default beat
// geometry and the serializer FSM state encoding.
package result_serializer_pkg;

  localparam int RESULT_W      = 255;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_NUM_WORDS = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Keeps the index bus at least one bit wide for single-beat configurations.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Result input and word-stream output of the serializer. The master side is
// the serializer; the slave side is the crypto top plus the PS consumer.
interface result_serializer_if
  import result_serializer_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) ();

  localparam int IDX_W = idx_width(NUM_WORDS);

  logic [RESULT_W-1:0] ser_data_in;
  logic                ser_data_valid;
  logic [WORD_W-1:0]   ser_word_out;
  logic                ser_word_valid;
  logic                ser_word_ready;
  logic                ser_word_last;
  logic [IDX_W-1:0]    ser_word_index;
  logic                ser_busy;
  logic                ser_overrun;

  modport master (
    input  ser_data_in, ser_data_valid, ser_word_ready,
    output ser_word_out, ser_word_valid, ser_word_last, ser_word_index,
           ser_busy, ser_overrun
  );

  modport slave (
    output ser_data_in, ser_data_valid, ser_word_ready,
    input  ser_word_out, ser_word_valid, ser_word_last, ser_word_index,
           ser_busy, ser_overrun
  );

endinterface

// File: rtl/result_serializer.sv
// Splits a 255-bit scalar-multiplication result into NUM_WORDS beats of
// WORD_W bits with a valid/ready handshake towards the PS side.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic              ser_clk,
  input  logic              ser_reset,
  result_serializer_if.master bus
);

  localparam int TOT_W = WORD_W * NUM_WORDS;
  localparam int IDX_W = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  ser_state_e        state_r;
  ser_state_e        state_nxt_s;
  logic              valid_q_r;
  logic [TOT_W-1:0]  cap_r;
  logic [IDX_W-1:0]  idx_r;
  logic              overrun_r;
  logic              new_edge_s;
  logic              xfer_s;
  logic              final_xfer_s;
  logic              load_s;
  logic [WORD_W-1:0] cap_words_s [NUM_WORDS];

  assign new_edge_s   = bus.ser_data_valid & ~valid_q_r;
  assign xfer_s       = (state_r == ST_SEND) & bus.ser_word_ready;
  assign final_xfer_s = xfer_s & (idx_r == LAST_IDX);
  // A result arriving on the final handshake is chained straight in.
  assign load_s       = new_edge_s & ((state_r == ST_IDLE) | final_xfer_s);

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    assign cap_words_s[gi] = cap_r[gi*WORD_W +: WORD_W];
  end

  // FSM state register
  always_ff @(posedge ser_clk or posedge ser_reset) begin
    if (ser_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (new_edge_s) state_nxt_s = ST_SEND;
        else            state_nxt_s = ST_IDLE;
      end
      ST_SEND: begin
        if (final_xfer_s && !new_edge_s) state_nxt_s = ST_IDLE;
        else                             state_nxt_s = ST_SEND;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Edge detector, capture register, beat index and sticky overrun flag
  always_ff @(posedge ser_clk or posedge ser_reset) begin
    if (ser_reset) begin
      valid_q_r <= 1'b0;
      cap_r     <= {TOT_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      valid_q_r <= bus.ser_data_valid;
      if (load_s) begin
        cap_r <= TOT_W'(bus.ser_data_in);
        idx_r <= {IDX_W{1'b0}};
      end else if (final_xfer_s) begin
        idx_r <= {IDX_W{1'b0}};
      end else if (xfer_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end
      if (new_edge_s && (state_r == ST_SEND) && !final_xfer_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // FSM outputs, all derived directly from registered state
  always_comb begin
    bus.ser_word_out   = cap_words_s[idx_r];
    bus.ser_word_index = idx_r;
    bus.ser_overrun    = overrun_r;
    bus.ser_word_valid = 1'b0;
    bus.ser_busy       = 1'b0;
    bus.ser_word_last  = 1'b0;
    case (state_r)
      ST_SEND: begin
        bus.ser_word_valid = 1'b1;
        bus.ser_busy       = 1'b1;
        bus.ser_word_last  = (idx_r == LAST_IDX);
      end
      ST_IDLE: begin
        bus.ser_word_valid = 1'b0;
        bus.ser_busy       = 1'b0;
        bus.ser_word_last  = 1'b0;
      end
      default: begin
        bus.ser_word_valid = 1'b0;
        bus.ser_busy       = 1'b0;
        bus.ser_word_last  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: a directed vector table, hand
// sequences for stall/overrun/chaining/reset, and a random run vs. a model.
module tb_result_serializer;

  localparam int WW = 32;
  localparam int NW = 8;
  localparam logic [255:0] D1_W = 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1122_3344_5566_7788_99AA_BBCC_DDEE_ABCD;

  logic ser_clk;
  logic ser_reset;

  result_serializer_if #(.WORD_W(WW), .NUM_WORDS(NW)) bus ();

  result_serializer #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
    .ser_clk   (ser_clk),
    .ser_reset (ser_reset),
    .bus       (bus)
  );

  initial ser_clk = 1'b0;
  always #5 ser_clk = ~ser_clk;

  typedef struct {
    logic        dv;
    logic        rdy;
    logic        e_valid;
    logic [2:0]  e_idx;
    logic        e_last;
    logic        e_busy;
    logic [31:0] e_word;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one pending result, beat counter, previous valid level.
  bit           m_active;
  logic [255:0] m_data;
  int           m_idx;
  bit           m_prev;
  bit           m_overrun;

  logic [31:0] beat_q[$];
  int          idx_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_data = '0; m_idx = 0; m_prev = 1'b0; m_overrun = 1'b0;
  endtask

  task automatic model_step(input logic dv, input logic rdy, input logic [254:0] din);
    bit edge_b;
    bit fin;
    edge_b = dv && !m_prev;
    fin    = m_active && rdy && (m_idx == NW - 1);
    if (!m_active) begin
      if (edge_b) begin m_active = 1'b1; m_data = {1'b0, din}; m_idx = 0; end
    end else if (fin) begin
      m_idx = 0;
      if (edge_b) m_data = {1'b0, din};
      else        m_active = 1'b0;
    end else begin
      if (rdy)    m_idx++;
      if (edge_b) m_overrun = 1'b1;
    end
    m_prev = dv;
  endtask

  task automatic check_model();
    logic [255:0] sh;
    sh = m_data >> (m_idx * WW);
    chk("valid",   bus.ser_word_valid, m_active);
    chk("busy",    bus.ser_busy, m_active);
    chk("index",   bus.ser_word_index, m_idx);
    chk("last",    bus.ser_word_last, m_active && (m_idx == NW - 1));
    chk("overrun", bus.ser_overrun, m_overrun);
    if (m_active) chk("word", bus.ser_word_out, sh[31:0]);
  endtask

  task automatic run_cycle(input logic dv, input logic rdy, input logic [254:0] din);
    bus.ser_data_valid = dv;
    bus.ser_word_ready = rdy;
    bus.ser_data_in    = din;
    check_model();
    if (bus.ser_word_valid && rdy) begin
      beat_q.push_back(bus.ser_word_out);
      idx_q.push_back(int'(bus.ser_word_index));
    end
    model_step(dv, rdy, din);
    @(negedge ser_clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_word"},    bus.ser_word_out, 64'd0);
    chk({tag, "_valid"},   bus.ser_word_valid, 64'd0);
    chk({tag, "_last"},    bus.ser_word_last, 64'd0);
    chk({tag, "_index"},   bus.ser_word_index, 64'd0);
    chk({tag, "_busy"},    bus.ser_busy, 64'd0);
    chk({tag, "_overrun"}, bus.ser_overrun, 64'd0);
  endtask

  function automatic logic [254:0] rand_result();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r[254:0];
  endfunction

  initial begin
    vec_t         tbl [10];
    logic [254:0] d1;
    logic [254:0] d2;
    logic [254:0] fmax;
    logic         dv;
    logic         rdy;
    int           c;

    d1   = D1_W[254:0];
    fmax = {255{1'b1}} - 255'd19;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_0000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 32'hDDEE_ABCD};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 32'h99AA_BBCC};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 32'h5566_7788};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 32'h1122_3344};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 32'h8765_4321};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 32'h0FED_CBA9};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 32'h9ABC_DEF0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 32'h1234_5678};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_0000};

    ser_reset          = 1'b1;
    bus.ser_data_valid = 1'b0;
    bus.ser_word_ready = 1'b0;
    bus.ser_data_in    = '0;
    model_reset();
    @(negedge ser_clk);
    @(negedge ser_clk);
    check_all_zero("reset");
    ser_reset = 1'b0;

    // Ready tied high; valid held high throughout must not retrigger.
    for (int i = 0; i < 10; i++) begin
      bus.ser_data_valid = tbl[i].dv;
      bus.ser_word_ready = tbl[i].rdy;
      bus.ser_data_in    = d1;
      chk("tbl_valid", bus.ser_word_valid, tbl[i].e_valid);
      chk("tbl_busy",  bus.ser_busy, tbl[i].e_busy);
      chk("tbl_index", bus.ser_word_index, tbl[i].e_idx);
      chk("tbl_last",  bus.ser_word_last, tbl[i].e_last);
      if (tbl[i].e_valid) chk("tbl_word", bus.ser_word_out, tbl[i].e_word);
      model_step(tbl[i].dv, tbl[i].rdy, d1);
      @(negedge ser_clk);
    end

    // Stall pattern 1,0,0,1: every beat delivered once, in order.
    beat_q.delete(); idx_q.delete();
    d2 = rand_result();
    run_cycle(1'b1, 1'b1, d2);
    c = 0;
    while (m_active && c < 60) begin
      run_cycle(1'b1, (c % 4 == 0) || (c % 4 == 3), d2);
      c++;
    end
    chk("stall_done", m_active, 1'b0);
    chk("stall_count", beat_q.size(), NW);
    for (int i = 0; i < idx_q.size(); i++) chk("stall_order", idx_q[i], i);

    // Field maximum 2^255-20.
    run_cycle(1'b0, 1'b1, fmax);
    beat_q.delete(); idx_q.delete();
    for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b1, fmax);
    chk("fmax_count", beat_q.size(), NW);
    if (beat_q.size() == NW) begin
      chk("fmax_w0", beat_q[0], 32'hFFFF_FFEC);
      for (int i = 1; i < 7; i++) chk("fmax_wmid", beat_q[i], 32'hFFFF_FFFF);
      chk("fmax_w7", beat_q[7], 32'h7FFF_FFFF);
    end

    // New edge while beat 3 is presented: dropped, overrun sticks.
    run_cycle(1'b0, 1'b1, d1);
    d2 = rand_result();
    beat_q.delete(); idx_q.delete();
    run_cycle(1'b1, 1'b1, d2);
    for (int i = 1; i < 4; i++) run_cycle(1'b0, 1'b1, d2);
    chk("ovr_at_beat3", bus.ser_word_index, 64'd3);
    run_cycle(1'b1, 1'b1, rand_result());
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b1, d1);
    chk("ovr_count", beat_q.size(), NW);
    chk("ovr_sticky", bus.ser_overrun, 64'd1);
    chk("ovr_idle", bus.ser_busy, 64'd0);

    // Edge on the final transfer chains the next result without a gap.
    run_cycle(1'b0, 1'b1, d1);
    run_cycle(1'b1, 1'b1, d1);
    for (int i = 1; i < 8; i++) run_cycle(1'b0, 1'b1, d1);
    d2 = rand_result();
    chk("chain_last", bus.ser_word_last, 64'd1);
    run_cycle(1'b1, 1'b1, d2);
    chk("chain_valid", bus.ser_word_valid, 64'd1);
    chk("chain_index", bus.ser_word_index, 64'd0);
    chk("chain_word",  bus.ser_word_out, {32'd0, d2[31:0]});
    for (int i = 0; i < 9; i++) run_cycle(1'b0, 1'b1, d2);

    // Asynchronous reset while beat 4 is stalled.
    run_cycle(1'b1, 1'b1, d1);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, d1);
    run_cycle(1'b0, 1'b0, d1);
    chk("rst_beat4", bus.ser_word_index, 64'd4);
    ser_reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge ser_clk);
    ser_reset = 1'b0;
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b1, d1);

    // Valid already high at reset release counts as a new result.
    ser_reset = 1'b1;
    bus.ser_data_valid = 1'b1;
    model_reset();
    @(negedge ser_clk);
    ser_reset = 1'b0;
    for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b1, d1);

    // Random traffic against the model.
    dv = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 3) dv = ~dv;
      rdy = ($urandom_range(0, 3) != 0);
      run_cycle(dv, rdy, rand_result());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
